// File: rtl/cl_axi_pkg.sv
// Shared AXI constants and the read-master state type for the cl_axi_* blocks.
//   AXI_BURST_INCR / AXI_RESP_OKAY / AXI_SIZE_64B : fixed AXI encodings
//   BEAT_BYTES / BEAT_SHIFT : bytes per 512-bit beat and its log2
//   PAGE_BYTES              : AXI bursts must not cross this boundary
//   rd_state_t              : read-master control states
package cl_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_64B   = 3'd6;

  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned BEAT_SHIFT = 6;
  localparam int unsigned PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/cl_axi_burst_calc.sv
// Combinational burst sizing for the read master.
//   rem_beats : beats still to be requested
//   page_off  : low 12 bits of the next burst address (64 B aligned)
//   beats     : min(rem_beats, MAX_BURST, beats left in the 4 KiB page)
//   arlen     : beats - 1 (meaningless when rem_beats is 0)
module cl_axi_burst_calc
  import cl_axi_pkg::*;
#(
  parameter int unsigned CNT_W     = 26,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic [CNT_W-1:0] rem_beats,
  input  logic [11:0]      page_off,
  output logic [8:0]       beats,
  output logic [7:0]       arlen
);

  logic [12:0] page_room;
  logic [6:0]  page_beats;
  logic [8:0]  cap;
  logic        unused_room_low;

  always_comb begin
    // Bytes to the next 4 KiB boundary: 64..4096 for an aligned address.
    page_room  = 13'(PAGE_BYTES) - {1'b0, page_off};
    page_beats = page_room[12:BEAT_SHIFT];

    if (rem_beats < CNT_W'(MAX_BURST)) begin
      cap = rem_beats[8:0];
    end else begin
      cap = 9'(MAX_BURST);
    end

    if (cap > {2'b00, page_beats}) begin
      beats = {2'b00, page_beats};
    end else begin
      beats = cap;
    end

    arlen = 8'(beats - 9'd1);
  end

  assign unused_room_low = ^page_room[BEAT_SHIFT-1:0];

endmodule

// File: rtl/cl_axi_read_master.sv
// AXI4 read-only master: fetches a contiguous region as INCR bursts that never
// cross a 4 KiB page, with a bounded number of bursts in flight, and streams
// the returned beats out over valid/ready.
//   clk, rst                     : clock, asynchronous active-high reset
//   start_i, base_addr_i,
//   len_bytes_i                  : command (sampled only when idle)
//   busy_o, done_o, err_o        : status (err_o sticky until next start)
//   m_ar*                        : AXI read-address channel
//   m_r*                         : AXI read-data channel
//   out_data_o/valid_o/last_o,
//   out_ready_i                  : beat stream to the downstream stage
module cl_axi_read_master
  import cl_axi_pkg::*;
#(
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned ID_W            = 16,
  parameter int unsigned RD_ID           = 0,
  parameter int unsigned LEN_W           = 32,
  parameter int unsigned MAX_BURST       = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_bytes_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,

  output logic [ID_W-1:0]   m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,

  input  logic [ID_W-1:0]   m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,

  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic              out_last_o,
  input  logic              out_ready_i
);

  localparam int unsigned CNT_W = LEN_W - BEAT_SHIFT;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  rd_state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic [CNT_W-1:0]  rcv_q;
  logic [OUT_W-1:0]  outst_q;
  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [8:0]        ar_beats_q;
  logic              err_q;

  logic [CNT_W-1:0]  start_beats;
  logic [CNT_W-1:0]  calc_rem;
  logic [11:0]       calc_off;
  logic [8:0]        calc_beats;
  logic [7:0]        calc_arlen;
  logic              idle_start;
  logic              launch;
  logic              ar_hs;
  logic              r_hs;
  logic              r_last_hs;
  logic              unused_inputs;

  assign start_beats = len_bytes_i[LEN_W-1:BEAT_SHIFT];
  assign idle_start  = (state == ST_IDLE) && start_i;

  // One calculator serves both the first burst (straight from the command
  // inputs, so AR goes out the cycle after start) and the following ones.
  assign calc_rem = (state == ST_IDLE) ? start_beats        : rem_q;
  assign calc_off = (state == ST_IDLE) ? base_addr_i[11:0]  : addr_q[11:0];

  cl_axi_burst_calc #(
    .CNT_W     (CNT_W),
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .rem_beats (calc_rem),
    .page_off  (calc_off),
    .beats     (calc_beats),
    .arlen     (calc_arlen)
  );

  assign launch    = (state == ST_ISSUE) && !arvalid_q && (rem_q != '0) &&
                     (outst_q < OUT_W'(MAX_OUTSTANDING));
  assign ar_hs     = arvalid_q & m_arready;
  assign r_hs      = busy_o & m_rvalid & m_rready;
  assign r_last_hs = r_hs & m_rlast;

  always_comb begin
    state_nxt = state;
    done_o    = 1'b0;
    busy_o    = 1'b1;
    unique case (state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_nxt = (start_beats == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ar_hs && (rem_q == CNT_W'(ar_beats_q))) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rcv_q == '0) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      rem_q      <= '0;
      rcv_q      <= '0;
      outst_q    <= '0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      ar_beats_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (idle_start) begin
        addr_q     <= base_addr_i;
        rem_q      <= start_beats;
        rcv_q      <= start_beats;
        err_q      <= 1'b0;
        arvalid_q  <= (start_beats != '0);
        araddr_q   <= base_addr_i;
        arlen_q    <= calc_arlen;
        ar_beats_q <= calc_beats;
      end else begin
        // The cursor (addr_q/rem_q) advances only on handshake, so the
        // presented AR payload stays frozen while the slave stalls.
        if (launch) begin
          arvalid_q  <= 1'b1;
          araddr_q   <= addr_q;
          arlen_q    <= calc_arlen;
          ar_beats_q <= calc_beats;
        end else if (ar_hs) begin
          arvalid_q <= 1'b0;
          addr_q    <= addr_q + ADDR_W'({ar_beats_q, 6'b0});
          rem_q     <= rem_q - CNT_W'(ar_beats_q);
        end

        if (r_hs) begin
          rcv_q <= rcv_q - CNT_W'(1);
          if (m_rresp != AXI_RESP_OKAY) begin
            err_q <= 1'b1;
          end
        end
      end

      unique case ({ar_hs, r_last_hs})
        2'b10:   outst_q <= outst_q + OUT_W'(1);
        2'b01:   if (outst_q != '0) outst_q <= outst_q - OUT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  assign m_arid    = ID_W'(RD_ID);
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = AXI_SIZE_64B;
  assign m_arburst = AXI_BURST_INCR;
  assign m_arvalid = arvalid_q;

  assign m_rready    = busy_o ? out_ready_i : 1'b1;
  assign out_data_o  = m_rdata;
  assign out_valid_o = busy_o & m_rvalid;
  assign out_last_o  = out_valid_o & (rcv_q == CNT_W'(1));
  assign err_o       = err_q;

  assign unused_inputs = ^{m_rid, len_bytes_i[BEAT_SHIFT-1:0]};

endmodule

// File: tb/tb_cl_axi_read_master.sv
module tb_cl_axi_read_master;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [63:0]  base_addr;
  logic [31:0]  len_bytes;
  logic         busy_o, done_o, err_o;
  logic [15:0]  m_arid;
  logic [63:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst;
  logic         m_arvalid;
  logic         ar_rdy;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         m_rready;
  logic [511:0] out_data_o;
  logic         out_valid_o, out_last_o;
  logic         out_ready;

  logic         r_en;
  logic [63:0]  err_addr;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_addr = '0;
  int          exp_total = 0;
  int          beats_seen = 0;
  int          done_cnt = 0;
  logic        err_at_done = 1'b0;
  int          max_inflight = 0;

  logic [63:0] log_addr[$];
  int          log_len[$];

  always #5 clk = ~clk;

  cl_axi_read_master #(
    .ADDR_W          (64),
    .DATA_W          (512),
    .ID_W            (16),
    .RD_ID           (0),
    .LEN_W           (32),
    .MAX_BURST       (64),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .base_addr_i (base_addr),
    .len_bytes_i (len_bytes),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .m_arid      (m_arid),
    .m_araddr    (m_araddr),
    .m_arlen     (m_arlen),
    .m_arsize    (m_arsize),
    .m_arburst   (m_arburst),
    .m_arvalid   (m_arvalid),
    .m_arready   (ar_rdy),
    .m_rid       (16'h0000),
    .m_rdata     (rdata),
    .m_rresp     (rresp),
    .m_rlast     (rlast),
    .m_rvalid    (rvalid),
    .m_rready    (m_rready),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: queues ARs, returns beats whose data is the beat address
  // replicated, flags SLVERR on the beat at err_addr.
  logic        have;
  logic [63:0] b_addr;
  int          b_left;
  int          inflight;
  logic [63:0] q_addr[$];
  int          q_len[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rresp  <= 2'b00;
      rdata  <= '0;
      have     = 1'b0;
      b_addr   = '0;
      b_left   = 0;
      inflight = 0;
      q_addr.delete();
      q_len.delete();
    end else begin
      if (m_arvalid && ar_rdy) begin
        q_addr.push_back(m_araddr);
        q_len.push_back(int'(m_arlen) + 1);
        log_addr.push_back(m_araddr);
        log_len.push_back(int'(m_arlen));
        inflight++;
      end
      if (rvalid && m_rready) begin
        if (rlast) inflight--;
        b_addr += 64;
        b_left--;
        if (b_left == 0) have = 1'b0;
      end
      if (inflight > max_inflight) max_inflight = inflight;
      if (!have && q_addr.size() != 0) begin
        have   = 1'b1;
        b_addr = q_addr.pop_front();
        b_left = q_len.pop_front();
      end
      if (have && r_en) begin
        rvalid <= 1'b1;
        rdata  <= {8{b_addr}};
        rlast  <= (b_left == 1);
        rresp  <= (b_addr == err_addr) ? 2'b10 : 2'b00;
      end else begin
        rvalid <= 1'b0;
      end
    end
  end

  // Output stream monitor: in-order data, last flag, rready mapping, done count.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) begin
        done_cnt++;
        err_at_done = err_o;
      end
      chk("rready_map", m_rready, busy_o ? out_ready : 1'b1);
      if (out_valid_o && out_ready) begin
        chk_data("beat_data", out_data_o, {8{exp_addr}});
        chk("beat_last", out_last_o, (beats_seen + 1 == exp_total));
        beats_seen++;
        exp_addr += 64;
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [63:0] b, input logic [31:0] l);
    @(posedge clk);
    #1;
    exp_addr   = b;
    exp_total  = int'(l >> 6);
    beats_seen = 0;
    done_cnt   = 0;
    base_addr  = b;
    len_bytes  = l;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      sample();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt, 1);
    sample();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_idle"}, busy_o, 0);
    chk({tag, "_beats"}, beats_seen, exp_total);
  endtask

  initial begin
    int lb;
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len_bytes = '0;
    ar_rdy    = 1'b1;
    out_ready = 1'b1;
    r_en      = 1'b1;
    err_addr  = '1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rready", m_rready, 1);
    rst = 1'b0;

    // 1: single 4-beat burst.
    lb = log_addr.size();
    start_xfer(64'h1000, 32'd256);
    sample();
    chk("t1_arvalid", m_arvalid, 1);
    chk("t1_araddr", m_araddr, 64'h1000);
    chk("t1_arlen", m_arlen, 3);
    chk("t1_arsize", m_arsize, 6);
    chk("t1_arburst", m_arburst, 1);
    chk("t1_arid", m_arid, 0);
    chk("t1_busy", busy_o, 1);
    wait_done(100, "t1");
    chk("t1_ar_count", log_addr.size() - lb, 1);
    chk("t1_err", err_o, 0);

    // 2: 4 KiB split, with AR stalled to check payload hold.
    lb = log_addr.size();
    ar_rdy = 1'b0;
    start_xfer(64'h0FC0, 32'd512);
    sample();
    chk("t2_arvalid", m_arvalid, 1);
    chk("t2_araddr0", m_araddr, 64'h0FC0);
    chk("t2_arlen0", m_arlen, 0);
    repeat (3) sample();
    chk("t2_hold_valid", m_arvalid, 1);
    chk("t2_hold_addr", m_araddr, 64'h0FC0);
    chk("t2_hold_len", m_arlen, 0);
    @(posedge clk);
    #1;
    ar_rdy = 1'b1;
    wait_done(100, "t2");
    chk("t2_ar_count", log_addr.size() - lb, 2);
    chk("t2_ar1_addr", log_addr[lb], 64'h0FC0);
    chk("t2_ar1_len", log_len[lb], 0);
    chk("t2_ar2_addr", log_addr[lb + 1], 64'h1000);
    chk("t2_ar2_len", log_len[lb + 1], 6);

    // 3: 300 beats with R stalled: outstanding limit, then the tail burst.
    lb = log_addr.size();
    r_en = 1'b0;
    start_xfer(64'h0, 32'd19200);
    repeat (40) sample();
    chk("t3_stall_ars", log_addr.size() - lb, 4);
    chk("t3_stall_arvalid", m_arvalid, 0);
    chk("t3_stall_busy", busy_o, 1);
    @(posedge clk);
    #1;
    r_en = 1'b1;
    wait_done(2000, "t3");
    chk("t3_ar_count", log_addr.size() - lb, 5);
    for (int i = 0; i < 4; i++) begin
      chk("t3_arlen_full", log_len[lb + i], 63);
      chk("t3_araddr_full", log_addr[lb + i], 64'(i) * 64'h1000);
    end
    chk("t3_arlen_tail", log_len[lb + 4], 43);
    chk("t3_araddr_tail", log_addr[lb + 4], 64'h4000);
    chk("t3_max_inflight", max_inflight, 4);

    // 4: downstream ready toggling every cycle.
    lb = log_addr.size();
    start_xfer(64'h2000, 32'd512);
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
      n++;
    end
    out_ready = 1'b1;
    wait_done(10, "t4");
    chk("t4_arlen", log_len[lb], 7);

    // 5: SLVERR on beat 2 of 4.
    err_addr = 64'h3040;
    start_xfer(64'h3000, 32'd256);
    sample();
    chk("t5_err_pre", err_o, 0);
    wait_done(100, "t5");
    chk("t5_err_at_done", err_at_done, 1);
    chk("t5_err_sticky", err_o, 1);
    err_addr = '1;

    // 6a: zero length, also clears the sticky error.
    lb = log_addr.size();
    start_xfer(64'h3000, 32'd0);
    sample();
    chk("t6_err_clear", err_o, 0);
    chk("t6_done", done_o, 1);
    chk("t6_busy", busy_o, 1);
    chk("t6_arvalid", m_arvalid, 0);
    sample();
    chk("t6_done_drop", done_o, 0);
    chk("t6_idle", busy_o, 0);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_no_ar", log_addr.size() - lb, 0);

    // 6b: reset while an AR is being presented.
    ar_rdy = 1'b0;
    start_xfer(64'h4000, 32'd256);
    sample();
    chk("t6r_arvalid_pre", m_arvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6r_arvalid", m_arvalid, 0);
    chk("t6r_busy", busy_o, 0);
    chk("t6r_done", done_o, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    ar_rdy = 1'b1;
    repeat (4) sample();
    chk("t6r_quiet_arvalid", m_arvalid, 0);
    chk("t6r_quiet_done", done_cnt, 0);

    // Recovery transfer after the mid-transfer reset.
    lb = log_addr.size();
    start_xfer(64'h5000, 32'd128);
    wait_done(100, "rec");
    chk("rec_arlen", log_len[lb], 1);
    chk("rec_araddr", log_addr[lb], 64'h5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
